// File: rtl/id_ex_decode_if.sv
// ID/EX pipeline register contents as seen by the execute stage.
// The decode stage drives it (master); the ALU/EX side reads it (slave).
interface id_ex_decode_if;
    logic        ex_valid;
    logic [2:0]  ALUOP;
    logic        Asrc;
    logic        Bsrc;
    logic        sra;
    logic        shdir;
    logic        sub;
    logic        jalr;
    logic [31:0] imm;
    logic [31:0] pc_out;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        jal;
    logic        illegal;
    logic [2:0]  funct3;

    modport master (
        output ex_valid, ALUOP, Asrc, Bsrc, sra, shdir, sub, jalr,
        output imm, pc_out, rs1, rs2, rd,
        output reg_write, mem_rd, mem_wr, branch, jal, illegal, funct3
    );

    modport slave (
        input ex_valid, ALUOP, Asrc, Bsrc, sra, shdir, sub, jalr,
        input imm, pc_out, rs1, rs2, rd,
        input reg_write, mem_rd, mem_wr, branch, jal, illegal, funct3
    );
endinterface

// File: rtl/id_ex_decode.sv
// RV32I decode stage: builds the ALU control word and immediate, registers them
// into ID/EX, and inserts a single bubble on a load-use hazard.
module id_ex_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [31:0] pc_in,
    input  logic        stall,
    input  logic        flush,
    output logic        hazard_stall,
    id_ex_decode_if.master ex
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        logic [2:0] aluop;
        logic       asrc;
        logic       bsrc;
        logic       sra;
        logic       shdir;
        logic       sub;
        logic       jalr;
        logic       reg_write;
        logic       mem_rd;
        logic       mem_wr;
        logic       branch;
        logic       jal;
        logic       illegal;
    } ctrl_t;

    function automatic logic signed [31:0] imm_i(input logic [11:0] f);
        return $signed({{20{f[11]}}, f});
    endfunction

    function automatic logic signed [31:0] imm_s(input logic [6:0] hi, input logic [4:0] lo);
        return $signed({{20{hi[6]}}, hi, lo});
    endfunction

    function automatic logic signed [31:0] imm_b(input logic s, input logic b11,
                                                 input logic [5:0] mid, input logic [3:0] lo);
        return $signed({{20{s}}, b11, mid, lo, 1'b0});
    endfunction

    function automatic logic signed [31:0] imm_u(input logic [19:0] f);
        return $signed({f, 12'h000});
    endfunction

    function automatic logic signed [31:0] imm_j(input logic s, input logic [7:0] hi,
                                                 input logic b11, input logic [9:0] lo);
        return $signed({{12{s}}, hi, b11, lo, 1'b0});
    endfunction

    logic [6:0]         w_opc_p0;
    logic [2:0]         w_f3_p0;
    logic [6:0]         w_f7_p0;
    logic [4:0]         w_rd_p0;
    logic [4:0]         w_rs1_p0;
    logic [4:0]         w_rs2_p0;
    logic [4:0]         w_rs1_sel_p0;
    logic               w_uses_rs1_p0;
    logic               w_uses_rs2_p0;
    ctrl_t              w_ctrl_p0;
    logic signed [31:0] w_imm_p0;
    logic               w_hazard_p0;

    ctrl_t              r_ctrl_p1;
    logic               r_vld_p1;
    logic signed [31:0] r_imm_p1;
    logic [31:0]        r_pc_p1;
    logic [4:0]         r_rs1_p1;
    logic [4:0]         r_rs2_p1;
    logic [4:0]         r_rd_p1;
    logic [2:0]         r_f3_p1;

    assign w_opc_p0 = instr[6:0];
    assign w_rd_p0  = instr[11:7];
    assign w_f3_p0  = instr[14:12];
    assign w_rs1_p0 = instr[19:15];
    assign w_rs2_p0 = instr[24:20];
    assign w_f7_p0  = instr[31:25];

    // ---- stage p0: combinational decode ----
    always_comb begin
        w_ctrl_p0     = '0;
        w_imm_p0      = '0;
        w_rs1_sel_p0  = w_rs1_p0;
        w_uses_rs1_p0 = 1'b1;
        w_uses_rs2_p0 = 1'b0;
        case (w_opc_p0)
            OPC_OP: begin
                w_ctrl_p0.aluop     = w_f3_p0;
                w_ctrl_p0.reg_write = 1'b1;
                w_ctrl_p0.sub       = instr[30] && (w_f3_p0 == 3'b000);
                w_ctrl_p0.sra       = instr[30] && (w_f3_p0 == 3'b101);
                w_ctrl_p0.shdir     = (w_f3_p0 == 3'b001);
                w_ctrl_p0.illegal   = !((w_f7_p0 == F7_ZERO) ||
                                        ((w_f7_p0 == F7_ALT) &&
                                         ((w_f3_p0 == 3'b000) || (w_f3_p0 == 3'b101))));
                w_uses_rs2_p0       = 1'b1;
            end
            OPC_OPIMM: begin
                w_ctrl_p0.aluop     = w_f3_p0;
                w_ctrl_p0.bsrc      = 1'b1;
                w_ctrl_p0.reg_write = 1'b1;
                w_ctrl_p0.shdir     = (w_f3_p0 == 3'b001);
                w_ctrl_p0.sra       = instr[30] && (w_f3_p0 == 3'b101);
                // Shifts carry only the shift amount; the upper field is a qualifier.
                if ((w_f3_p0 == 3'b001) || (w_f3_p0 == 3'b101)) begin
                    w_imm_p0          = $signed({27'd0, w_rs2_p0});
                    w_ctrl_p0.illegal = !((w_f7_p0 == F7_ZERO) ||
                                          ((w_f3_p0 == 3'b101) && (w_f7_p0 == F7_ALT)));
                end else begin
                    w_imm_p0 = imm_i(instr[31:20]);
                end
            end
            OPC_LUI: begin
                w_ctrl_p0.bsrc      = 1'b1;
                w_ctrl_p0.reg_write = 1'b1;
                w_imm_p0            = imm_u(instr[31:12]);
                w_rs1_sel_p0        = 5'd0;
                w_uses_rs1_p0       = 1'b0;
            end
            OPC_AUIPC: begin
                w_ctrl_p0.asrc      = 1'b1;
                w_ctrl_p0.bsrc      = 1'b1;
                w_ctrl_p0.reg_write = 1'b1;
                w_imm_p0            = imm_u(instr[31:12]);
                w_uses_rs1_p0       = 1'b0;
            end
            OPC_JAL: begin
                w_ctrl_p0.asrc      = 1'b1;
                w_ctrl_p0.bsrc      = 1'b1;
                w_ctrl_p0.jal       = 1'b1;
                w_ctrl_p0.reg_write = 1'b1;
                w_imm_p0            = imm_j(instr[31], instr[19:12], instr[20], instr[30:21]);
                w_uses_rs1_p0       = 1'b0;
            end
            OPC_JALR: begin
                w_ctrl_p0.jalr      = 1'b1;
                w_ctrl_p0.asrc      = 1'b1;
                w_ctrl_p0.bsrc      = 1'b1;
                w_ctrl_p0.reg_write = 1'b1;
                w_ctrl_p0.illegal   = (w_f3_p0 != 3'b000);
                w_imm_p0            = imm_i(instr[31:20]);
            end
            OPC_BRANCH: begin
                w_ctrl_p0.sub     = 1'b1;
                w_ctrl_p0.branch  = 1'b1;
                w_ctrl_p0.illegal = (w_f3_p0 == 3'b010) || (w_f3_p0 == 3'b011);
                w_imm_p0          = imm_b(instr[31], instr[7], instr[30:25], instr[11:8]);
                w_uses_rs2_p0     = 1'b1;
            end
            OPC_LOAD: begin
                w_ctrl_p0.bsrc      = 1'b1;
                w_ctrl_p0.mem_rd    = 1'b1;
                w_ctrl_p0.reg_write = 1'b1;
                w_imm_p0            = imm_i(instr[31:20]);
            end
            OPC_STORE: begin
                w_ctrl_p0.bsrc   = 1'b1;
                w_ctrl_p0.mem_wr = 1'b1;
                w_imm_p0         = imm_s(instr[31:25], instr[11:7]);
                w_uses_rs2_p0    = 1'b1;
            end
            default: begin
                w_ctrl_p0.illegal = 1'b1;
            end
        endcase
        // An illegal instruction travels down the pipe but must have no side effects.
        if (w_ctrl_p0.illegal) begin
            w_ctrl_p0.reg_write = 1'b0;
            w_ctrl_p0.mem_rd    = 1'b0;
            w_ctrl_p0.mem_wr    = 1'b0;
            w_ctrl_p0.branch    = 1'b0;
            w_ctrl_p0.jal       = 1'b0;
            w_ctrl_p0.jalr      = 1'b0;
        end
        if (w_rd_p0 == 5'd0) begin
            w_ctrl_p0.reg_write = 1'b0;
        end
    end

    // Load in EX whose destination is a source of the instruction now in decode.
    assign w_hazard_p0 = r_vld_p1 && r_ctrl_p1.mem_rd && (r_rd_p1 != 5'd0) && instr_valid &&
                         ((w_uses_rs1_p0 && (w_rs1_p0 == r_rd_p1)) ||
                          (w_uses_rs2_p0 && (w_rs2_p0 == r_rd_p1)));
    assign hazard_stall = w_hazard_p0 && !flush && !stall;

    // ---- stage p1: ID/EX register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_ctrl_p1 <= '0;
        end else if (flush) begin
            r_vld_p1  <= 1'b0;
            r_ctrl_p1 <= '0;
        end else if (!stall) begin
            if (w_hazard_p0) begin
                r_vld_p1  <= 1'b0;
                r_ctrl_p1 <= '0;
            end else begin
                r_vld_p1  <= instr_valid;
                r_ctrl_p1 <= w_ctrl_p0;
            end
        end
    end

    // Operand fields are don't-care whenever ex_valid is low, so they only need to hold on stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_imm_p1 <= '0;
            r_pc_p1  <= '0;
            r_rs1_p1 <= '0;
            r_rs2_p1 <= '0;
            r_rd_p1  <= '0;
            r_f3_p1  <= '0;
        end else if (flush || !stall) begin
            r_imm_p1 <= w_imm_p0;
            r_pc_p1  <= pc_in;
            r_rs1_p1 <= w_rs1_sel_p0;
            r_rs2_p1 <= w_rs2_p0;
            r_rd_p1  <= w_rd_p0;
            r_f3_p1  <= w_f3_p0;
        end
    end

    assign ex.ex_valid  = r_vld_p1;
    assign ex.ALUOP     = r_ctrl_p1.aluop;
    assign ex.Asrc      = r_ctrl_p1.asrc;
    assign ex.Bsrc      = r_ctrl_p1.bsrc;
    assign ex.sra       = r_ctrl_p1.sra;
    assign ex.shdir     = r_ctrl_p1.shdir;
    assign ex.sub       = r_ctrl_p1.sub;
    assign ex.jalr      = r_ctrl_p1.jalr;
    assign ex.reg_write = r_ctrl_p1.reg_write;
    assign ex.mem_rd    = r_ctrl_p1.mem_rd;
    assign ex.mem_wr    = r_ctrl_p1.mem_wr;
    assign ex.branch    = r_ctrl_p1.branch;
    assign ex.jal       = r_ctrl_p1.jal;
    assign ex.illegal   = r_ctrl_p1.illegal;
    assign ex.imm       = r_imm_p1;
    assign ex.pc_out    = r_pc_p1;
    assign ex.rs1       = r_rs1_p1;
    assign ex.rs2       = r_rs2_p1;
    assign ex.rd        = r_rd_p1;
    assign ex.funct3    = r_f3_p1;

endmodule

// File: doc/id_ex_decode.md
# id_ex_decode

Decode-to-execute pipeline stage for the RISCVX RV32I core. It is the driving end of the ALU control interface. It takes a fetched instruction and its PC, decodes them into the ALU control word (ALUOP, Asrc, Bsrc, sra, shdir, sub, jalr) plus the sign-extended immediate, and registers the result into the ID/EX pipeline register. It also detects load-use hazards, and inserts a bubble while asking fetch to hold.

## Interface
- No parameters; all widths fixed (XLEN = 32).
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset; sampled on rising edge of clk
- instr_valid  in  1  instr/pc_in carry a real instruction this cycle
- instr  in  32  fetched instruction word
- pc_in  in  32  address of instr
- stall  in  1  downstream (EX/MEM) cannot accept; hold ID/EX register
- flush  in  1  branch/jump redirect; kill the instruction being registered
- hazard_stall  out  1  combinational; fetch must hold instr/pc_in this cycle
- ex_valid  out  1  ID/EX register holds a real instruction
- ALUOP  out  3  ALU function select (000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and)
- Asrc  out  1  1 = ALU A operand is PC, 0 = rs1 data
- Bsrc  out  1  1 = ALU B operand is imm, 0 = rs2 data
- sra  out  1  arithmetic right shift
- shdir  out  1  1 = left shift
- sub  out  1  subtract in add/sub path
- jalr  out  1  JALR: ALU B forced to 4, branch target base = rs1
- imm  out  32  sign-extended immediate
- pc_out  out  32  registered PC
- rs1, rs2, rd  out  5 each  register indices
- reg_write, mem_rd, mem_wr, branch, jal, illegal  out  1 each  class flags
- funct3  out  3  passed through for branch condition and load/store size

## Operation
- Decode is combinational from instr and is registered on the next edge. Register priority per edge: !rst_n > flush > stall > hazard bubble > load.
  - !rst_n or flush: ex_valid = 0 and all control flags 0.
  - stall: every register holds.
  - hazard: ex_valid = 0; fetch holds.
  - otherwise: load the decode result, with ex_valid = instr_valid.
- Opcode decode:
  - OP 0110011: ALUOP = funct3, Bsrc = 0.
    - sub = instr[30] & (funct3 == 000); sra = instr[30] & (funct3 == 101); shdir = (funct3 == 001).
    - funct7 must be 0000000, or 0100000 with funct3 000 or 101; anything else is illegal.
  - OP-IMM 0010011: as OP, but Bsrc = 1, I-immediate, sub = 0.
    - sra = instr[30] only for funct3 101.
    - For shifts, imm[11:5] must be 0000000, or 0100000 for srai; anything else is illegal.
  - LUI 0110111: Bsrc = 1, Asrc = 0, rs1 forced to 0, U-immediate (instr[31:12], 12'b0).
  - AUIPC 0010111: Asrc = 1, Bsrc = 1, U-immediate.
  - JAL 1101111: Asrc = 1, Bsrc = 1, J-immediate, jal = 1, reg_write = 1. The link value PC+4 is selected at writeback.
  - JALR 1100111 (funct3 000 only): jalr = 1, Asrc = 1, I-immediate, reg_write = 1.
  - BRANCH 1100011: Asrc = 0, Bsrc = 0, sub = 1, B-immediate, branch = 1, reg_write = 0. funct3 010 and 011 are illegal.
  - LOAD 0000011: Bsrc = 1, I-immediate, mem_rd = 1, reg_write = 1.
  - STORE 0100011: Bsrc = 1, S-immediate, mem_wr = 1.
  - Any other opcode, or instr[1:0] != 11: illegal.
- Unless stated above, ALUOP = 000 and sub/sra/shdir/jalr = 0.
- Illegal instruction: registered with illegal = 1, ex_valid = instr_valid, and reg_write/mem_rd/mem_wr/branch/jal/jalr = 0.
- reg_write is forced to 0 when rd == 0.
- hazard_stall = ex_valid & mem_rd & (rd != 0) & instr_valid & ((uses_rs1 & rs1_new == rd) | (uses_rs2 & rs2_new == rd)).
  - uses_rs2 only for OP, BRANCH and STORE.
  - uses_rs1 for everything except LUI, AUIPC and JAL.
  - hazard_stall is masked to 0 when flush or stall is asserted.

## Timing
- Latency: 1 cycle from instr sample to ID/EX outputs.
- Reset values: every output is 0, including imm, pc_out and hazard_stall.
- A load-use hazard costs exactly one bubble. On the next cycle the load has advanced, ex_valid = 0, and hazard_stall deasserts.
- Simultaneous stall and hazard: stall wins and the register holds.
- Simultaneous flush and stall: flush wins.
- Reset asserted mid-stream clears the register on that edge regardless of stall.

## Test plan
- Reset, then add x3,x1,x2 (0x002081B3) with instr_valid = 1 -> next cycle ex_valid = 1, ALUOP = 000, sub = 0, Bsrc = 0, rd = 3, reg_write = 1.
- sub 0x402081B3, then srai x5,x6,3 (0x40335293).
  - sub -> sub = 1.
  - srai -> ALUOP = 101, sra = 1, Bsrc = 1, imm = 0x00000003.
- beq x1,x2,-4 (0xFE208EE3) -> branch = 1, sub = 1, imm = 0xFFFFFFFC, reg_write = 0. lui x1,0x12345 (0x123450B7) -> imm = 0x12345000, rs1 = 0.
- lw x5,8(x1) (0x0080A283) followed by add x6,x5,x0 (0x00028333).
  - hazard_stall = 1 for one cycle, ex_valid = 0 for that cycle.
  - The add then registers with rs1 = 5.
- stall held 3 cycles -> outputs frozen. flush with stall -> ex_valid = 0. 0xFFFFFFFF -> illegal = 1, reg_write = 0.
